// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between VGA scanout and CPU screen accesses.
// VGA wins by default; a buffered CPU request is forced through after MAX_WAIT blocked cycles.
module vram_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic              vga_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic {BUF_EMPTY, BUF_PENDING} buf_state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU_READ} tag_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    buf_state_t        buf_state_q, buf_state_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    tag_t              tag_q, tag_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              vga_rvalid_q, vga_rvalid_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              vga_overrun_q, vga_overrun_d;

    logic              buffered;
    logic              accept;
    logic              grant_vga;
    logic              grant_cpu;
    logic              cand_we;
    logic [ADDR_W-1:0] cand_addr;
    logic [DATA_W-1:0] cand_wdata;

    // The held request always beats the incoming one, which keeps CPU order intact.
    assign buffered   = (buf_state_q == BUF_PENDING);
    assign cpu_ready  = !reset && !buffered;
    assign accept     = cpu_req && cpu_ready;
    assign cand_we    = buffered ? buf_we_q    : cpu_we;
    assign cand_addr  = buffered ? buf_addr_q  : cpu_addr;
    assign cand_wdata = buffered ? buf_wdata_q : cpu_wdata;

    always_comb begin
        grant_vga     = 1'b0;
        grant_cpu     = 1'b0;
        buf_state_d   = buf_state_q;
        buf_we_d      = buf_we_q;
        buf_addr_d    = buf_addr_q;
        buf_wdata_d   = buf_wdata_q;
        wait_cnt_d    = wait_cnt_q;
        vga_overrun_d = 1'b0;

        if (!reset) begin
            if (buffered && wait_cnt_q == WAIT_LIMIT) begin
                grant_cpu     = 1'b1;
                buf_state_d   = BUF_EMPTY;
                wait_cnt_d    = '0;
                vga_overrun_d = vga_req;
            end else if (vga_req) begin
                grant_vga = 1'b1;
                // The limit case was taken above, so this can never pass WAIT_LIMIT.
                if (buffered) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
                if (accept) begin
                    buf_state_d = BUF_PENDING;
                    buf_we_d    = cpu_we;
                    buf_addr_d  = cpu_addr;
                    buf_wdata_d = cpu_wdata;
                end
            end else if (buffered || accept) begin
                grant_cpu   = 1'b1;
                buf_state_d = BUF_EMPTY;
                wait_cnt_d  = '0;
            end
        end

        if (grant_vga) begin
            tag_d = TAG_VGA;
        end else if (grant_cpu && !cand_we) begin
            tag_d = TAG_CPU_READ;
        end else begin
            tag_d = TAG_NONE;
        end

        vga_rvalid_d = (tag_q == TAG_VGA);
        cpu_rvalid_d = (tag_q == TAG_CPU_READ);
        vga_rdata_d  = vga_rvalid_d ? ram_rdata : vga_rdata_q;
        cpu_rdata_d  = cpu_rvalid_d ? ram_rdata : cpu_rdata_q;
    end

    assign ram_addr  = grant_cpu ? cand_addr : vga_addr;
    assign ram_we    = grant_cpu && cand_we;
    assign ram_wdata = cand_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_state_q   <= BUF_EMPTY;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            buf_wdata_q   <= '0;
            wait_cnt_q    <= '0;
            tag_q         <= TAG_NONE;
            vga_rdata_q   <= '0;
            cpu_rdata_q   <= '0;
            vga_rvalid_q  <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            vga_overrun_q <= 1'b0;
        end else begin
            buf_state_q   <= buf_state_d;
            buf_we_q      <= buf_we_d;
            buf_addr_q    <= buf_addr_d;
            buf_wdata_q   <= buf_wdata_d;
            wait_cnt_q    <= wait_cnt_d;
            tag_q         <= tag_d;
            vga_rdata_q   <= vga_rdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            vga_rvalid_q  <= vga_rvalid_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            vga_overrun_q <= vga_overrun_d;
        end
    end

    assign vga_rdata   = vga_rdata_q;
    assign vga_rvalid  = vga_rvalid_q;
    assign vga_overrun = vga_overrun_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_rvalid  = cpu_rvalid_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_vram_arbiter;
    localparam int ADDR_W      = 14;
    localparam int DATA_W      = 16;
    localparam int MAX_WAIT    = 8;
    localparam int RAND_CYCLES = 3000;

    logic              clk = 1'b0;
    logic              reset;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              vga_overrun;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata),
        .vga_rvalid(vga_rvalid), .vga_overrun(vga_overrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int numChecks = 0;
    int numPassed = 0;

    function automatic logic [DATA_W-1:0] initWord(int i);
        if (i == 5) return 16'h12AB;
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // VRAM macro: synchronous read, data one cycle after the address.
    logic [DATA_W-1:0] ram_mem [0:16383];
    initial begin : ram_proc
        logic [ADDR_W-1:0] a;
        logic              we;
        logic [DATA_W-1:0] wd;
        for (int i = 0; i < 16384; i++) ram_mem[i] = initWord(i);
        forever begin
            @(negedge clk);
            #2;
            a  = ram_addr;
            we = ram_we;
            wd = ram_wdata;
            @(posedge clk);
            ram_rdata <= ram_mem[a];
            if (we === 1'b1) ram_mem[a] = wd;
        end
    end

    // Reference model state: the CPU buffer, blocked-cycle count, memory contents and
    // a queue of read results scheduled for the cycle they must become visible.
    typedef struct {
        int                due;
        bit                is_vga;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic [DATA_W-1:0] shadow [0:16383];
    ret_t              rets[$];
    int                cyc = 0;
    bit                m_buf_valid = 0;
    logic              m_buf_we;
    logic [ADDR_W-1:0] m_buf_addr;
    logic [DATA_W-1:0] m_buf_wdata;
    int                m_wait = 0;
    logic [DATA_W-1:0] m_vga_rdata = '0;
    logic [DATA_W-1:0] m_cpu_rdata = '0;
    bit                m_ovr_pending = 0;
    bit                m_accepted = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual === expected) begin
            numPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic modelStep();
        bit                exp_vrv = 0;
        bit                exp_crv = 0;
        bit                exp_ovr;
        bit                exp_ready;
        bit                accept;
        bit                g_cpu = 0;
        logic              op_we;
        logic [ADDR_W-1:0] op_addr;
        logic [DATA_W-1:0] op_wd;
        ret_t              r;

        while (rets.size() > 0 && rets[0].due == cyc) begin
            r = rets.pop_front();
            if (r.is_vga) begin
                m_vga_rdata = r.data;
                exp_vrv = 1;
            end else begin
                m_cpu_rdata = r.data;
                exp_crv = 1;
            end
        end
        exp_ovr = m_ovr_pending;
        m_ovr_pending = 0;

        checkOutput("vga_rvalid", 32'(vga_rvalid), 32'(exp_vrv));
        checkOutput("vga_rdata", 32'(vga_rdata), 32'(m_vga_rdata));
        checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
        checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
        checkOutput("vga_overrun", 32'(vga_overrun), 32'(exp_ovr));
        exp_ready = !reset && !m_buf_valid;
        checkOutput("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
        m_accepted = 0;

        if (reset) begin
            rets.delete();
            m_buf_valid = 0;
            m_wait = 0;
            m_vga_rdata = '0;
            m_cpu_rdata = '0;
            cyc++;
            return;
        end

        accept = cpu_req && exp_ready;
        m_accepted = accept;
        if (m_buf_valid && m_wait == MAX_WAIT) begin
            g_cpu = 1;
            {op_we, op_addr, op_wd} = {m_buf_we, m_buf_addr, m_buf_wdata};
            m_ovr_pending = vga_req;
            m_buf_valid = 0;
            m_wait = 0;
        end else if (vga_req) begin
            if (m_buf_valid) m_wait = m_wait + 1;
            if (accept) begin
                m_buf_valid = 1;
                {m_buf_we, m_buf_addr, m_buf_wdata} = {cpu_we, cpu_addr, cpu_wdata};
            end
            rets.push_back('{cyc + 2, 1'b1, shadow[vga_addr]});
        end else if (m_buf_valid || accept) begin
            g_cpu = 1;
            if (m_buf_valid) {op_we, op_addr, op_wd} = {m_buf_we, m_buf_addr, m_buf_wdata};
            else             {op_we, op_addr, op_wd} = {cpu_we, cpu_addr, cpu_wdata};
            m_buf_valid = 0;
            m_wait = 0;
        end

        if (g_cpu) begin
            checkOutput("ram_addr", 32'(ram_addr), 32'(op_addr));
            checkOutput("ram_we", 32'(ram_we), 32'(op_we));
            if (op_we) begin
                checkOutput("ram_wdata", 32'(ram_wdata), 32'(op_wd));
                shadow[op_addr] = op_wd;
            end else begin
                rets.push_back('{cyc + 2, 1'b0, shadow[op_addr]});
            end
        end else begin
            checkOutput("ram_addr", 32'(ram_addr), 32'(vga_addr));
            checkOutput("ram_we", 32'(ram_we), 32'd0);
        end
        cyc++;
    endtask

    // Drives one cycle's inputs at the falling edge, then checks that cycle against the model.
    task automatic applyStimulus(input logic rst, input logic vreq, input logic [ADDR_W-1:0] vaddr,
                                 input logic creq, input logic cwe, input logic [ADDR_W-1:0] caddr,
                                 input logic [DATA_W-1:0] cwd);
        @(negedge clk);
        reset     = rst;
        vga_req   = vreq;
        vga_addr  = vaddr;
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwd;
        #1;
        modelStep();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin : driver
        bit                hold = 0;
        int                mode = 0;
        logic              rst, vreq, creq, cwe;
        logic [ADDR_W-1:0] vaddr, caddr;
        logic [DATA_W-1:0] cwd;

        for (int i = 0; i < 16384; i++) shadow[i] = initWord(i);
        {reset, vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata} = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("reset_cpu_ready", 32'(cpu_ready), 32'd0);
        checkOutput("reset_vga_rdata", 32'(vga_rdata), 32'd0);

        // VGA-only fetch.
        applyStimulus(1'b0, 1'b1, 14'h0005, 1'b0, 1'b0, '0, '0);
        checkOutput("t1_ram_addr", 32'(ram_addr), 32'h0005);
        checkOutput("t1_cpu_ready_after_reset", 32'(cpu_ready), 32'd1);
        idleCycle();
        idleCycle();
        checkOutput("t1_vga_rvalid", 32'(vga_rvalid), 32'd1);
        checkOutput("t1_vga_rdata", 32'(vga_rdata), 32'h12AB);
        idleCycle();
        checkOutput("t1_vga_rvalid_drop", 32'(vga_rvalid), 32'd0);
        checkOutput("t1_vga_rdata_held", 32'(vga_rdata), 32'h12AB);

        // CPU bypass write then read-back.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 14'h3FFF, 16'hBEEF);
        checkOutput("t2_ready_w", 32'(cpu_ready), 32'd1);
        checkOutput("t2_ram_we", 32'(ram_we), 32'd1);
        checkOutput("t2_ram_wdata", 32'(ram_wdata), 32'hBEEF);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h3FFF, '0);
        checkOutput("t2_ready_r", 32'(cpu_ready), 32'd1);
        checkOutput("t2_ram_addr_r", 32'(ram_addr), 32'h3FFF);
        idleCycle();
        idleCycle();
        checkOutput("t2_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        checkOutput("t2_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

        // Contention: CPU read buffered behind three VGA cycles.
        applyStimulus(1'b0, 1'b1, 14'h0020, 1'b1, 1'b0, 14'h0010, '0);
        checkOutput("t3_ready_accept", 32'(cpu_ready), 32'd1);
        for (int k = 1; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 14'(32 + k), 1'b0, 1'b0, '0, '0);
            checkOutput("t3_ready_blocked", 32'(cpu_ready), 32'd0);
            checkOutput("t3_ram_we_blocked", 32'(ram_we), 32'd0);
        end
        idleCycle();
        checkOutput("t3_ready_issue", 32'(cpu_ready), 32'd0);
        checkOutput("t3_ram_addr_issue", 32'(ram_addr), 32'h0010);
        idleCycle();
        idleCycle();
        checkOutput("t3_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        checkOutput("t3_cpu_rdata", 32'(cpu_rdata), 32'h4A4A);

        // Starvation escape after MAX_WAIT blocked cycles.
        applyStimulus(1'b0, 1'b1, 14'h0030, 1'b1, 1'b1, 14'h0040, 16'hCAFE);
        checkOutput("t4_ready_accept", 32'(cpu_ready), 32'd1);
        for (int k = 1; k <= MAX_WAIT; k++) begin
            applyStimulus(1'b0, 1'b1, 14'h0030, 1'b0, 1'b0, '0, '0);
            checkOutput("t4_ram_we_blocked", 32'(ram_we), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 14'h0030, 1'b0, 1'b0, '0, '0);
        checkOutput("t4_forced_we", 32'(ram_we), 32'd1);
        checkOutput("t4_forced_addr", 32'(ram_addr), 32'h0040);
        checkOutput("t4_forced_wdata", 32'(ram_wdata), 32'hCAFE);
        idleCycle();
        checkOutput("t4_overrun", 32'(vga_overrun), 32'd1);
        checkOutput("t4_ready_after", 32'(cpu_ready), 32'd1);
        idleCycle();
        checkOutput("t4_overrun_pulse", 32'(vga_overrun), 32'd0);
        checkOutput("t4_dropped_rvalid", 32'(vga_rvalid), 32'd0);

        // Reset while a CPU read is in flight.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 14'h3FFF, '0);
        checkOutput("t5_ram_addr", 32'(ram_addr), 32'h3FFF);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t5_ready_in_reset", 32'(cpu_ready), 32'd0);
        idleCycle();
        checkOutput("t5_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("t5_cpu_rdata", 32'(cpu_rdata), 32'd0);
        checkOutput("t5_vga_rdata", 32'(vga_rdata), 32'd0);
        checkOutput("t5_ready_after", 32'(cpu_ready), 32'd1);
        idleCycle();
        checkOutput("t5_cpu_rvalid_late", 32'(cpu_rvalid), 32'd0);

        // Simultaneous VGA and CPU requests with an empty buffer.
        applyStimulus(1'b0, 1'b1, 14'h0001, 1'b1, 1'b1, 14'h0050, 16'h1234);
        checkOutput("t6_ready", 32'(cpu_ready), 32'd1);
        checkOutput("t6_ram_addr_vga", 32'(ram_addr), 32'h0001);
        applyStimulus(1'b0, 1'b1, 14'h0002, 1'b0, 1'b0, '0, '0);
        checkOutput("t6_ready_next", 32'(cpu_ready), 32'd0);
        checkOutput("t6_ram_we_held", 32'(ram_we), 32'd0);
        idleCycle();
        checkOutput("t6_issue_we", 32'(ram_we), 32'd1);
        checkOutput("t6_issue_addr", 32'(ram_addr), 32'h0050);
        idleCycle();
        checkOutput("t6_ready_free", 32'(cpu_ready), 32'd1);

        // Random traffic; the CPU holds a request until it is accepted.
        {creq, cwe, caddr, cwd} = '0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            if (c % 64 == 0) mode = int'($urandom_range(0, 2));
            rst   = ($urandom_range(0, 499) == 0);
            vreq  = (mode == 1) ? 1'b1 :
                    (mode == 2) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 2) == 0);
            vaddr = 14'($urandom_range(0, 63));
            if (!hold) begin
                creq  = $urandom_range(0, 1) == 1;
                cwe   = $urandom_range(0, 1) == 1;
                caddr = ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 31));
                cwd   = 16'($urandom);
            end
            applyStimulus(rst, vreq, vaddr, creq, cwe, caddr, cwd);
            hold = creq && !m_accepted && !rst;
        end
        repeat (4) idleCycle();

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end
endmodule
